// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060136_ifu_fetch_pkg
// Description : Shared widths, reset PC and fetch FSM state encoding for IFU.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060136_ifu_fetch_pkg;

    localparam int BITS_W = 64;
    localparam int INST_W = 32;

    localparam logic [BITS_W-1:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060136_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060136_ifu_fetch
// Description : Single-outstanding instruction fetch unit with a one-entry
//               slot towards IDU and redirect squashing of in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060136_ifu_fetch
    import ysyx_23060136_ifu_fetch_pkg::*;
#(
    parameter logic [63:0] RST_PC = ysyx_23060136_ifu_fetch_pkg::RST_PC
) (
    input  logic                clk,
    input  logic                rst,

    output logic [BITS_W-1:0]   IFU_o_araddr,
    output logic                IFU_o_arvalid,
    input  logic                IFU_i_arready,
    input  logic [INST_W-1:0]   IFU_i_rdata,
    input  logic [1:0]          IFU_i_rresp,
    input  logic                IFU_i_rvalid,
    output logic                IFU_o_rready,

    input  logic                EXU_i_redirect,
    input  logic [BITS_W-1:0]   EXU_i_redirect_pc,

    output logic [BITS_W-1:0]   IFU_o_pc,
    output logic [INST_W-1:0]   IFU_o_inst,
    output logic                IFU_o_commit,
    output logic                IFU_o_fetch_err,
    output logic                IFU_o_valid,
    input  logic                IDU_i_ready
);

    ifu_state_e         r_state;
    ifu_state_e         w_state_nxt;

    logic [BITS_W-1:0]  r_fetch_pc;
    logic [BITS_W-1:0]  w_fetch_pc_nxt;
    logic [BITS_W-1:0]  r_redir_pc;
    logic [BITS_W-1:0]  w_redir_pc_nxt;
    logic               r_redir_pend;
    logic               w_redir_pend_nxt;

    logic [BITS_W-1:0]  r_slot_pc;
    logic [INST_W-1:0]  r_slot_inst;
    logic               r_slot_err;
    logic               w_slot_load;
    logic               w_resp_err;

    assign w_resp_err = (IFU_i_rresp != 2'b00);

    // ------------------------------------------------------------------------
    // Next-state logic; a redirect takes priority over every other event.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_redir_pc_nxt   = EXU_i_redirect ? EXU_i_redirect_pc : r_redir_pc;
        w_redir_pend_nxt = r_redir_pend;
        w_slot_load      = 1'b0;

        case (r_state)
            S_REQ: begin
                // The request already on the bus is never withdrawn; a
                // redirect only marks its eventual response as wrong-path.
                if (EXU_i_redirect) begin
                    w_redir_pend_nxt = 1'b1;
                end
                if (IFU_i_arready) begin
                    w_state_nxt = (EXU_i_redirect || r_redir_pend) ? S_DROP : S_WAIT;
                end
            end

            S_WAIT: begin
                if (EXU_i_redirect) begin
                    if (IFU_i_rvalid) begin
                        w_state_nxt      = S_REQ;
                        w_fetch_pc_nxt   = EXU_i_redirect_pc;
                        w_redir_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt      = S_DROP;
                        w_redir_pend_nxt = 1'b1;
                    end
                end else if (IFU_i_rvalid) begin
                    w_slot_load    = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 64'd4;
                    w_state_nxt    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (EXU_i_redirect) begin
                    w_state_nxt    = S_REQ;
                    w_fetch_pc_nxt = EXU_i_redirect_pc;
                end else if (IDU_i_ready) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_DROP: begin
                // Latest redirect target wins, even one arriving with rvalid.
                if (IFU_i_rvalid) begin
                    w_state_nxt      = S_REQ;
                    w_fetch_pc_nxt   = w_redir_pc_nxt;
                    w_redir_pend_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RST_PC;
            r_redir_pc   <= '0;
            r_redir_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_redir_pend <= w_redir_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_pc   <= '0;
            r_slot_inst <= '0;
            r_slot_err  <= 1'b0;
        end else if (w_slot_load) begin
            r_slot_pc   <= r_fetch_pc;
            r_slot_inst <= IFU_i_rdata;
            r_slot_err  <= w_resp_err;
        end
    end

    // Handshake outputs are gated by reset so they drop the moment it asserts.
    assign IFU_o_arvalid   = rst && (r_state == S_REQ);
    assign IFU_o_araddr    = IFU_o_arvalid ? r_fetch_pc : '0;
    assign IFU_o_rready    = rst && ((r_state == S_WAIT) || (r_state == S_DROP));
    assign IFU_o_valid     = rst && (r_state == S_HOLD);
    assign IFU_o_commit    = IFU_o_valid;

    assign IFU_o_pc        = r_slot_pc;
    assign IFU_o_inst      = r_slot_inst;
    assign IFU_o_fetch_err = r_slot_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ysyx_23060136_ifu_fetch
// Description : Directed bench with a bus slave and a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060136_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic        commit;
    logic        fetch_err;
    logic        valid;
    logic        idu_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vcnt     = 0;

    int         ar_lat  = 0;
    int         r_lat   = 0;
    logic [1:0] err_cfg = 2'b00;

    ysyx_23060136_ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .IFU_o_araddr      (araddr),
        .IFU_o_arvalid     (arvalid),
        .IFU_i_arready     (arready),
        .IFU_i_rdata       (rdata),
        .IFU_i_rresp       (rresp),
        .IFU_i_rvalid      (rvalid),
        .IFU_o_rready      (rready),
        .EXU_i_redirect    (redirect),
        .EXU_i_redirect_pc (redirect_pc),
        .IFU_o_pc          (o_pc),
        .IFU_o_inst        (o_inst),
        .IFU_o_commit      (commit),
        .IFU_o_fetch_err   (fetch_err),
        .IFU_o_valid       (valid),
        .IDU_i_ready       (idu_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (valid) vcnt++;
    end

    // Memory slave: decides at each falling edge, using what the DUT showed
    // during the cycle that just closed.
    logic        p_arvalid = 1'b0;
    logic        p_rready  = 1'b0;
    logic [63:0] p_araddr  = '0;
    logic [63:0] s_addr    = '0;
    bit          s_busy    = 1'b0;
    int          ar_cnt    = 0;
    int          r_cnt     = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            s_busy = 1'b0; ar_cnt = 0; arready = 1'b0; rvalid = 1'b0;
            p_arvalid = 1'b0; p_rready = 1'b0;
        end else begin
            if (rvalid && p_rready) begin
                rvalid = 1'b0;
                s_busy = 1'b0;
            end
            if (arready && p_arvalid) begin
                s_busy = 1'b1; s_addr = p_araddr; r_cnt = r_lat; ar_cnt = 0;
            end
            arready = 1'b0;
            if (s_busy && !rvalid) begin
                if (r_cnt == 0) begin
                    rvalid = 1'b1; rdata = mem_word(s_addr); rresp = err_cfg;
                end else begin
                    r_cnt--;
                end
            end
            if (!s_busy && arvalid) begin
                if (ar_cnt >= ar_lat) arready = 1'b1;
                else ar_cnt++;
            end
            p_arvalid = arvalid; p_araddr = araddr; p_rready = rready;
        end
    end

    // Reference model in transaction terms: an open address phase, owed data
    // (possibly wrong-path), a pending jump, and a full/empty IDU slot.
    bit          m_addr_open = 1'b1;
    bit          m_data_owed = 1'b0;
    bit          m_wrong     = 1'b0;
    bit          m_jump      = 1'b0;
    bit          m_slot      = 1'b0;
    bit          m_restart   = 1'b0;
    logic [63:0] m_req_pc    = 64'h8000_0000;
    logic [63:0] m_tgt       = '0;
    logic [63:0] m_spc       = '0;
    logic [31:0] m_sinst     = '0;
    logic        m_serr      = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_addr_open = 1'b1; m_data_owed = 1'b0; m_wrong = 1'b0; m_jump = 1'b0;
            m_slot = 1'b0; m_req_pc = 64'h8000_0000; m_tgt = '0;
        end else begin
            m_restart = 1'b0;
            if (redirect) begin
                m_tgt  = redirect_pc;
                m_jump = 1'b1;
            end
            if (m_addr_open) begin
                if (arready) begin
                    m_addr_open = 1'b0; m_data_owed = 1'b1; m_wrong = m_jump;
                end
            end else if (m_data_owed) begin
                if (rvalid) begin
                    m_data_owed = 1'b0;
                    if (m_wrong || m_jump) begin
                        m_restart = 1'b1;
                    end else begin
                        m_slot = 1'b1; m_spc = m_req_pc; m_sinst = rdata; m_serr = (rresp != 2'b00);
                    end
                end
            end else if (m_slot) begin
                if (m_jump) begin
                    m_slot = 1'b0; m_restart = 1'b1;
                end else if (idu_ready) begin
                    m_slot = 1'b0; m_addr_open = 1'b1; m_req_pc = m_spc + 64'd4;
                end
            end
            if (m_restart) begin
                m_addr_open = 1'b1; m_req_pc = m_tgt; m_jump = 1'b0; m_wrong = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_arvalid", 64'(arvalid), 64'd0);
            chk("rst_araddr",  araddr, 64'd0);
            chk("rst_rready",  64'(rready), 64'd0);
            chk("rst_valid",   64'(valid), 64'd0);
            chk("rst_commit",  64'(commit), 64'd0);
            chk("rst_pc",      o_pc, 64'd0);
            chk("rst_inst",    64'(o_inst), 64'd0);
            chk("rst_err",     64'(fetch_err), 64'd0);
        end else begin
            chk("m_arvalid", 64'(arvalid), 64'(m_addr_open));
            if (m_addr_open) chk("m_araddr", araddr, m_req_pc);
            chk("m_rready", 64'(rready), 64'(m_data_owed));
            chk("m_valid",  64'(valid), 64'(m_slot));
            chk("m_commit", 64'(commit), 64'(m_slot));
            if (m_slot) begin
                chk("m_pc",   o_pc, m_spc);
                chk("m_inst", 64'(o_inst), 64'(m_sinst));
                chk("m_err",  64'(fetch_err), 64'(m_serr));
            end
        end
    end

    task automatic wait_arvalid(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (arvalid) begin ok = 1'b1; break; end
        end
        chk({nm, "_arvalid_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid) begin ok = 1'b1; break; end
        end
        chk({nm, "_valid_timeout"}, 64'(ok), 64'd1);
    endtask

    int c0, c1, v0;

    initial begin
        repeat (3) @(negedge clk);
        chk("lit_rst_arvalid", 64'(arvalid), 64'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Zero-wait fetch and throughput
        wait_arvalid("first");
        c0 = cyc;
        chk("lit_first_araddr", araddr, 64'h8000_0000);
        wait_valid("first");
        chk("lit_first_pc", o_pc, 64'h8000_0000);
        chk("lit_first_inst", 64'(o_inst), 64'h0000_0013);
        chk("lit_first_err", 64'(fetch_err), 64'd0);
        wait_arvalid("second");
        c1 = cyc;
        chk("lit_second_araddr", araddr, 64'h8000_0004);
        chk("lit_throughput", 64'(c1 - c0), 64'd3);

        // IDU stall: slot held
        idu_ready = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("lit_stall_valid", 64'(valid), 64'd1);
            chk("lit_stall_pc", o_pc, 64'h8000_0004);
            chk("lit_stall_inst", 64'(o_inst), 64'h0000_0017);
            chk("lit_stall_arvalid", 64'(arvalid), 64'd0);
            @(negedge clk);
        end
        idu_ready = 1'b1;

        // Redirect in WAIT, overwritten during DROP, late response
        r_lat = 3;
        wait_arvalid("third");
        chk("lit_third_araddr", araddr, 64'h8000_0008);
        @(negedge clk);
        chk("lit_wait_rready", 64'(rready), 64'd1);
        v0 = vcnt;
        redirect = 1'b1; redirect_pc = 64'h8000_0F00;
        @(negedge clk);
        redirect_pc = 64'h8000_1000;
        @(negedge clk);
        redirect = 1'b0; r_lat = 0; ar_lat = 4;
        wait_arvalid("redir1");
        chk("lit_redir1_araddr", araddr, 64'h8000_1000);
        chk("lit_redir1_novalid", 64'(vcnt - v0), 64'd0);

        // Slow arready with a redirect during the address phase
        v0 = vcnt;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 64'h8000_2000;
        chk("lit_slow_araddr", araddr, 64'h8000_1000);
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lit_slow_arvalid", 64'(arvalid), 64'd1);
            chk("lit_slow_araddr_hold", araddr, 64'h8000_1000);
            @(negedge clk);
        end
        ar_lat = 0; err_cfg = 2'b10;
        wait_arvalid("redir2");
        chk("lit_redir2_araddr", araddr, 64'h8000_2000);
        chk("lit_redir2_novalid", 64'(vcnt - v0), 64'd0);

        // Error response, then redirect in HOLD with IDU ready; PC wrap
        wait_valid("err");
        chk("lit_err_flag", 64'(fetch_err), 64'd1);
        chk("lit_err_pc", o_pc, 64'h8000_2000);
        chk("lit_err_inst", 64'(o_inst), 64'h0000_2013);
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; err_cfg = 2'b00;
        @(negedge clk);
        redirect = 1'b0;
        chk("lit_hold_redir_valid", 64'(valid), 64'd0);
        chk("lit_hold_redir_araddr", araddr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid("wrap");
        chk("lit_wrap_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("lit_wrap_inst", 64'(o_inst), 64'h7FFF_FFEF);
        wait_arvalid("wrap");
        chk("lit_wrap_araddr", araddr, 64'd0);

        // Reset during WAIT
        r_lat = 3;
        @(negedge clk);
        chk("lit_pre_rst_rready", 64'(rready), 64'd1);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("lit_mid_rst_arvalid", 64'(arvalid), 64'd0);
        chk("lit_mid_rst_rready", 64'(rready), 64'd0);
        chk("lit_mid_rst_araddr", araddr, 64'd0);
        r_lat = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        wait_arvalid("after_rst");
        chk("lit_after_rst_araddr", araddr, 64'h8000_0000);
        wait_valid("after_rst");
        chk("lit_after_rst_inst", 64'(o_inst), 64'h0000_0013);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
